// File: rtl/updown_count_ctrl.sv
// Sequencer for an external N-bit up/down counter: runs it up to a latched limit,
// down to zero, or up then down, with a valid/ready command port and abort.
`timescale 1ns/1ps
module updown_count_ctrl #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [N-1:0] cmd_limit,
  input  logic         abort,
  input  logic [N-1:0] count_val,
  output logic         count_clr,
  output logic         count_en,
  output logic         count_dir,
  output logic         busy,
  output logic         done,
  output logic         aborted
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t       state_r, state_nx_s;
  logic [N-1:0] limit_r;
  logic         pp_r;
  logic         aborted_r;
  logic         dir_r;
  logic         clr_s, en_s, dir_s, abort_take_s, accept_s, pp_clear_s;

  // Next-state and Mealy counter controls; abort gates clr/en in the same cycle.
  always_comb begin
    state_nx_s   = state_r;
    clr_s        = 1'b0;
    en_s         = 1'b0;
    dir_s        = dir_r;
    abort_take_s = 1'b0;
    accept_s     = 1'b0;
    pp_clear_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid) begin
          accept_s = 1'b1;
          case (cmd_op)
            2'b00:   state_nx_s = S_CLR;
            2'b01:   state_nx_s = S_DOWN;
            2'b10:   state_nx_s = S_CLR;
            default: state_nx_s = S_DONE;
          endcase
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_CLR: begin
        if (abort) begin
          abort_take_s = 1'b1;
          state_nx_s   = S_IDLE;
        end else begin
          clr_s      = 1'b1;
          state_nx_s = S_UP;
        end
      end
      S_UP: begin
        dir_s = 1'b1;
        if (abort) begin
          abort_take_s = 1'b1;
          state_nx_s   = S_IDLE;
        end else if (count_val != limit_r) begin
          en_s = 1'b1;
        end else if (pp_r) begin
          pp_clear_s = 1'b1;
          state_nx_s = S_DOWN;
        end else begin
          state_nx_s = S_DONE;
        end
      end
      S_DOWN: begin
        dir_s = 1'b0;
        if (abort) begin
          abort_take_s = 1'b1;
          state_nx_s   = S_IDLE;
        end else if (count_val != {N{1'b0}}) begin
          en_s = 1'b1;
        end else begin
          state_nx_s = S_DONE;
        end
      end
      S_DONE: begin
        state_nx_s = S_IDLE;
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // State, latched command and direction memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      limit_r   <= {N{1'b0}};
      pp_r      <= 1'b0;
      aborted_r <= 1'b0;
      dir_r     <= 1'b1;
    end else begin
      state_r   <= state_nx_s;
      aborted_r <= abort_take_s;
      dir_r     <= dir_s;
      if (accept_s) begin
        limit_r <= cmd_limit;
        pp_r    <= (cmd_op == 2'b10);
      end else if (pp_clear_s) begin
        pp_r <= 1'b0;
      end else begin
        pp_r <= pp_r;
      end
    end
  end

  assign count_clr = clr_s;
  assign count_en  = en_s;
  assign count_dir = dir_s;
  assign cmd_ready = (state_r == S_IDLE);
  assign busy      = (state_r != S_IDLE);
  assign done      = (state_r == S_DONE);
  assign aborted   = aborted_r;

endmodule
